// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer for the E stage: captures the result at start,
// holds busy for a fixed number of cycles, then commits HI/LO.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        mf_sel,
  output logic        busy,
  output logic        hilo_busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;

  // Divisor forced to 1 on divide-by-zero so the datapath never produces X;
  // the result is discarded via pend_we anyway.
  always_comb begin
    div_b  = (md_b == 32'd0) ? 32'd1 : md_b;
    prod_s = $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
    prod_u = {32'd0, md_a} * {32'd0, md_b};
    quo_s  = $signed(md_a) / $signed(div_b);
    rem_s  = $signed(md_a) % $signed(div_b);
    quo_u  = md_a / div_b;
    rem_u  = md_a % div_b;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;

    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = (md_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
              pend_lo_d = (md_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
              pend_we_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_RUN;
              busy_d    = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = (md_op == OP_DIV) ? rem_s : rem_u;
              pend_lo_d = (md_op == OP_DIV) ? quo_s : quo_u;
              pend_we_d = (md_b != 32'd0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
              busy_d    = 1'b1;
            end
            OP_MTHI: hi_d = md_a;
            OP_MTLO: lo_d = md_a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Any md_start here is dropped; the stall unit keeps it from happening.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: every register, including the pending result, is reset so an aborted op leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign busy      = busy_q;
  assign hilo_busy = busy_q | (md_start & (md_op >= OP_MULT) & (md_op <= OP_DIVU));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mf_data   = mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: arithmetic results, busy timing, mthi/mtlo,
// divide-by-zero, start-during-run and reset mid-operation.
module tb_md_ctrl;

  logic        clk;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        mf_sel;
  logic        busy;
  logic        hilo_busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int errors = 0;
  int checks = 0;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_a      (md_a),
    .md_b      (md_b),
    .mf_sel    (mf_sel),
    .busy      (busy),
    .hilo_busy (hilo_busy),
    .hi        (hi),
    .lo        (lo),
    .mf_data   (mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; md_start = 1'b0; md_op = 3'd0; md_a = '0; md_b = '0; mf_sel = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    cmp("reset_hi", hi, 32'h0);
    cmp("reset_lo", lo, 32'h0);
    cmp("reset_busy", {31'd0, busy}, 32'd0);
    cmp("reset_hilo_busy", {31'd0, hilo_busy}, 32'd0);
    mf_sel = 1'b1; #1;
    cmp("reset_mf_hi", mf_data, 32'h0);
    mf_sel = 1'b0; #1;
    cmp("reset_mf_lo", mf_data, 32'h0);
  endtask

  // Issue one op, measure the busy window, then check the committed HI/LO.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    md_start = 1'b1; md_op = op; md_a = a; md_b = b;
    #1;
    cmp({name, "_hilo_busy_start"}, {31'd0, hilo_busy}, 32'd1);
    tick();
    md_start = 1'b0; md_op = 3'd0;
    #1;
    cmp({name, "_hilo_busy_run"}, {31'd0, hilo_busy}, 32'd1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    cmp({name, "_busy_cycles"}, 32'(cnt), 32'(exp_cycles));
    cmp({name, "_hilo_busy_end"}, {31'd0, hilo_busy}, 32'd0);
    cmp({name, "_hi"}, hi, exp_hi);
    cmp({name, "_lo"}, lo, exp_lo);
    mf_sel = 1'b1; #1;
    cmp({name, "_mf_hi"}, mf_data, exp_hi);
    mf_sel = 1'b0; #1;
    cmp({name, "_mf_lo"}, mf_data, exp_lo);
  endtask

  task automatic test_mult();
    run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
  endtask

  task automatic test_div();
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
  endtask

  task automatic test_mt_and_div_zero();
    md_start = 1'b1; md_op = 3'd5; md_a = 32'h1111_1111;
    tick();
    cmp("mthi_busy", {31'd0, busy}, 32'd0);
    cmp("mthi_hi", hi, 32'h1111_1111);
    md_op = 3'd6; md_a = 32'h2222_2222;
    tick();
    md_start = 1'b0; md_op = 3'd0;
    #1;
    cmp("mtlo_busy", {31'd0, busy}, 32'd0);
    cmp("mtlo_lo", lo, 32'h2222_2222);
    cmp("mtlo_hi_kept", hi, 32'h1111_1111);
    run_op("divzero", 3'd3, 32'd5, 32'd0, 10, 32'h1111_1111, 32'h2222_2222);
  endtask

  task automatic test_start_during_run();
    int cnt;
    md_start = 1'b1; md_op = 3'd1; md_a = 32'd3; md_b = 32'd4;
    tick();
    md_start = 1'b0; md_op = 3'd0;
    cnt = 1;
    tick();
    cnt++;
    md_start = 1'b1; md_op = 3'd6; md_a = 32'h0000_DEAD;
    tick();
    md_start = 1'b0; md_op = 3'd0;
    #1;
    cmp("run_ignore_lo_mid", lo, 32'h2222_2222);
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    cmp("run_ignore_busy_cycles", 32'(cnt), 32'd5);
    cmp("run_ignore_lo", lo, 32'd12);
    cmp("run_ignore_hi", hi, 32'd0);
  endtask

  task automatic test_reset_mid_op();
    int late_commit;
    md_start = 1'b1; md_op = 3'd3; md_a = 32'd100; md_b = 32'd7;
    tick();
    md_start = 1'b0; md_op = 3'd0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    cmp("abort_busy", {31'd0, busy}, 32'd0);
    cmp("abort_hi", hi, 32'd0);
    cmp("abort_lo", lo, 32'd0);
    late_commit = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) late_commit++;
    end
    cmp("abort_no_late_commit", 32'(late_commit), 32'd0);
    run_op("after_abort", 3'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_and_div_zero();
    test_start_during_run();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
